// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with FWFT/registered-read modes, fill level, thresholds, flush and watermark.
// Optional macro SYNC_FIFO_FLEX_WATERMARK_EN adds clr_max input and max_level output.
module sync_fifo_flex #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned FIFO_DEPTH    = 16,
    parameter int unsigned FWFT          = 0,
    parameter int unsigned AFULL_THRESH  = FIFO_DEPTH - 2,
    parameter int unsigned AEMPTY_THRESH = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          flush,
    input  logic [DATA_WIDTH-1:0]         data_in,
    input  logic                          wr,
    output logic [DATA_WIDTH-1:0]         data_out,
    output logic                          valid,
    input  logic                          rd,
    output logic                          empty,
    output logic                          full,
    output logic                          almost_empty,
    output logic                          almost_full,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          underrun,
`ifdef SYNC_FIFO_FLEX_WATERMARK_EN
    input  logic                          clr_max,
    output logic [$clog2(FIFO_DEPTH):0]   max_level,
`endif
    output logic                          overrun
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam logic [LW-1:0] DepthL   = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0] AfullL   = LW'(AFULL_THRESH);
    localparam logic [LW-1:0] AemptyL  = LW'(AEMPTY_THRESH);
    localparam logic [LW-1:0] OneL     = LW'(1);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two and at least 2");
    end

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic [LW-1:0] wr_ptr_q, wr_ptr_d;
    logic [LW-1:0] rd_ptr_q, rd_ptr_d;
    logic          underrun_q, underrun_d;
    logic          overrun_q, overrun_d;
    logic          do_read, do_write;
    logic [AW-1:0] rd_idx, wr_idx;

    assign rd_idx = rd_ptr_q[AW-1:0];
    assign wr_idx = wr_ptr_q[AW-1:0];

    // Extra pointer MSB makes the modular difference distinguish full from empty.
    assign level        = wr_ptr_q - rd_ptr_q;
    assign empty        = (level == '0);
    assign full         = (level == DepthL);
    assign almost_empty = (level <= AemptyL);
    assign almost_full  = (level >= AfullL);
    assign underrun     = underrun_q;
    assign overrun      = overrun_q;

    always_comb begin
        do_read    = en & rd & ~empty & ~flush;
        // A full FIFO still takes a write when a read frees a slot on the same edge.
        do_write   = en & wr & ~flush & (~full | do_read);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (en && flush) begin
            rd_ptr_d = wr_ptr_q;
        end else begin
            if (do_write) wr_ptr_d = wr_ptr_q + OneL;
            if (do_read)  rd_ptr_d = rd_ptr_q + OneL;
        end
        underrun_d = en & rd & empty & ~wr & ~flush;
        overrun_d  = en & wr & full & ~rd & ~flush;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            underrun_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            underrun_q <= underrun_d;
            overrun_q  <= overrun_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_write) begin
            mem_q[wr_idx] <= data_in;
        end
    end

    if (FWFT != 0) begin : g_fwft
        // Forced to zero while empty so the output is defined during and after reset.
        assign data_out = empty ? '0 : mem_q[rd_idx];
        assign valid    = ~empty;
    end else begin : g_reg_read
        logic [DATA_WIDTH-1:0] dout_q, dout_d;
        logic                  valid_q, valid_d;

        always_comb begin
            dout_d  = dout_q;
            valid_d = valid_q;
            if (en) begin
                valid_d = do_read;
                if (do_read) dout_d = mem_q[rd_idx];
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                dout_q  <= '0;
                valid_q <= 1'b0;
            end else begin
                dout_q  <= dout_d;
                valid_q <= valid_d;
            end
        end

        assign data_out = dout_q;
        assign valid    = valid_q;
    end

`ifdef SYNC_FIFO_FLEX_WATERMARK_EN
    logic [LW-1:0] max_level_q, max_level_d;
    logic [LW-1:0] level_next;

    always_comb begin
        level_next  = wr_ptr_d - rd_ptr_d;
        max_level_d = max_level_q;
        if (en && flush) begin
            max_level_d = '0;
        end else if (en && clr_max) begin
            max_level_d = level_next;
        end else if (level_next > max_level_q) begin
            max_level_d = level_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_level_q <= '0;
        end else begin
            max_level_q <= max_level_d;
        end
    end

    assign max_level = max_level_q;
`endif

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Directed testbench for sync_fifo_flex: registered-read instance (a) and FWFT instance (b).
module tb_sync_fifo_flex;

    localparam int DW = 32;
    localparam int DEPTH = 16;
    localparam int LW = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          a_en = 1'b1, a_flush = 1'b0, a_wr = 1'b0, a_rd = 1'b0;
    logic [DW-1:0] a_din = '0, a_dout;
    logic          a_valid, a_empty, a_full, a_ae, a_af, a_under, a_over;
    logic [LW-1:0] a_level;

    logic          b_en = 1'b1, b_flush = 1'b0, b_wr = 1'b0, b_rd = 1'b0;
    logic [DW-1:0] b_din = '0, b_dout;
    logic          b_valid, b_empty, b_full, b_ae, b_af, b_under, b_over;
    logic [LW-1:0] b_level;

`ifdef SYNC_FIFO_FLEX_WATERMARK_EN
    logic          a_clr_max = 1'b0, b_clr_max = 1'b0;
    logic [LW-1:0] a_max, b_max;
`endif

    int checks = 0;
    int errors = 0;

    sync_fifo_flex #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .FWFT(0)) u_a (
        .clk(clk), .rst(rst), .en(a_en), .flush(a_flush), .data_in(a_din), .wr(a_wr),
        .data_out(a_dout), .valid(a_valid), .rd(a_rd), .empty(a_empty), .full(a_full),
        .almost_empty(a_ae), .almost_full(a_af), .level(a_level), .underrun(a_under),
`ifdef SYNC_FIFO_FLEX_WATERMARK_EN
        .clr_max(a_clr_max), .max_level(a_max),
`endif
        .overrun(a_over)
    );

    sync_fifo_flex #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .FWFT(1)) u_b (
        .clk(clk), .rst(rst), .en(b_en), .flush(b_flush), .data_in(b_din), .wr(b_wr),
        .data_out(b_dout), .valid(b_valid), .rd(b_rd), .empty(b_empty), .full(b_full),
        .almost_empty(b_ae), .almost_full(b_af), .level(b_level), .underrun(b_under),
`ifdef SYNC_FIFO_FLEX_WATERMARK_EN
        .clr_max(b_clr_max), .max_level(b_max),
`endif
        .overrun(b_over)
    );

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({a_empty, a_full, a_ae, a_af} !== 4'b1010) begin
            errors++;
            $display("FAIL reset_flags_a got %b want 1010", {a_empty, a_full, a_ae, a_af});
        end
        checks++;
        if ({a_level, a_valid, a_under, a_over} !== {5'd0, 3'b000}) begin
            errors++;
            $display("FAIL reset_state_a got lvl=%0d v=%b u=%b o=%b want 0 0 0 0",
                     a_level, a_valid, a_under, a_over);
        end
        checks++;
        if (a_dout !== 32'h0) begin
            errors++;
            $display("FAIL reset_dout_a got %h want 0", a_dout);
        end
        checks++;
        if ({b_empty, b_full, b_ae, b_af, b_valid, b_dout} !== {5'b10100, 32'h0}) begin
            errors++;
            $display("FAIL reset_b got e=%b f=%b ae=%b af=%b v=%b d=%h want 1 0 1 0 0 0",
                     b_empty, b_full, b_ae, b_af, b_valid, b_dout);
        end
`ifdef SYNC_FIFO_FLEX_WATERMARK_EN
        checks++;
        if ({a_max, b_max} !== 10'd0) begin
            errors++;
            $display("FAIL reset_max got a=%0d b=%0d want 0 0", a_max, b_max);
        end
`endif
        rst = 1'b0;
        tick();
    endtask

    task automatic test_fill_overrun();
        logic [LW+1:0] exp_v;
        for (int i = 0; i < DEPTH; i++) begin
            a_wr = 1'b1;
            a_din = DW'(i);
            tick();
            exp_v = {LW'(i + 1), (i + 1 >= 14), (i == 15)};
            checks++;
            if ({a_level, a_af, a_full} !== exp_v) begin
                errors++;
                $display("FAIL fill_%0d got lvl=%0d af=%b full=%b want lvl=%0d af=%b full=%b",
                         i, a_level, a_af, a_full, exp_v[LW+1:2], exp_v[1], exp_v[0]);
            end
        end
        a_din = 32'h10;
        tick();
        checks++;
        if ({a_full, a_level, a_over} !== {1'b1, 5'd16, 1'b1}) begin
            errors++;
            $display("FAIL overrun got full=%b lvl=%0d ovr=%b want 1 16 1",
                     a_full, a_level, a_over);
        end
        a_wr = 1'b0;
        tick();
        checks++;
        if ({a_level, a_over} !== {5'd16, 1'b0}) begin
            errors++;
            $display("FAIL overrun_pulse got lvl=%0d ovr=%b want 16 0", a_level, a_over);
        end
`ifdef SYNC_FIFO_FLEX_WATERMARK_EN
        checks++;
        if (a_max !== 5'd16) begin
            errors++;
            $display("FAIL max_after_fill got %0d want 16", a_max);
        end
`endif
    endtask

    task automatic test_full_rw();
        logic [DW-1:0] exp_d;
        a_wr = 1'b1;
        a_rd = 1'b1;
        a_din = 32'hAA;
        tick();
        a_wr = 1'b0;
        checks++;
        if ({a_level, a_valid, a_dout, a_over} !== {5'd16, 1'b1, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL full_rw got lvl=%0d v=%b d=%h o=%b want 16 1 0 0",
                     a_level, a_valid, a_dout, a_over);
        end
        for (int k = 0; k < 16; k++) begin
            tick();
            exp_d = (k < 15) ? DW'(k + 1) : 32'hAA;
            checks++;
            if ({a_valid, a_dout} !== {1'b1, exp_d}) begin
                errors++;
                $display("FAIL drain_%0d got v=%b d=%h want 1 %h", k, a_valid, a_dout, exp_d);
            end
        end
        a_rd = 1'b0;
        tick();
        checks++;
        if ({a_valid, a_dout, a_empty, a_level, a_under} !== {1'b0, 32'hAA, 1'b1, 5'd0, 1'b0})
        begin
            errors++;
            $display("FAIL drain_end got v=%b d=%h e=%b lvl=%0d u=%b want 0 aa 1 0 0",
                     a_valid, a_dout, a_empty, a_level, a_under);
        end
    endtask

    task automatic test_underrun();
        a_rd = 1'b1;
        tick();
        checks++;
        if ({a_under, a_valid, a_level} !== {1'b1, 1'b0, 5'd0}) begin
            errors++;
            $display("FAIL underrun got u=%b v=%b lvl=%0d want 1 0 0", a_under, a_valid, a_level);
        end
        a_wr = 1'b1;
        a_din = 32'h55;
        tick();
        a_wr = 1'b0;
        checks++;
        if ({a_under, a_valid, a_level} !== {1'b0, 1'b0, 5'd1}) begin
            errors++;
            $display("FAIL rw_empty got u=%b v=%b lvl=%0d want 0 0 1", a_under, a_valid, a_level);
        end
        tick();
        a_rd = 1'b0;
        checks++;
        if ({a_valid, a_dout, a_level} !== {1'b1, 32'h55, 5'd0}) begin
            errors++;
            $display("FAIL read_55 got v=%b d=%h lvl=%0d want 1 55 0", a_valid, a_dout, a_level);
        end
    endtask

    task automatic test_fwft();
        b_wr = 1'b1;
        b_din = 32'h1234;
        tick();
        b_wr = 1'b0;
        checks++;
        if ({b_valid, b_dout, b_empty} !== {1'b1, 32'h1234, 1'b0}) begin
            errors++;
            $display("FAIL fwft_show got v=%b d=%h e=%b want 1 1234 0", b_valid, b_dout, b_empty);
        end
        b_rd = 1'b1;
        tick();
        b_rd = 1'b0;
        checks++;
        if ({b_valid, b_empty} !== 2'b01) begin
            errors++;
            $display("FAIL fwft_pop got v=%b e=%b want 0 1", b_valid, b_empty);
        end
        b_wr = 1'b1;
        b_din = 32'h11;
        tick();
        b_din = 32'h22;
        tick();
        b_wr = 1'b0;
        checks++;
        if ({b_dout, b_level} !== {32'h11, 5'd2}) begin
            errors++;
            $display("FAIL fwft_two got d=%h lvl=%0d want 11 2", b_dout, b_level);
        end
        b_rd = 1'b1;
        tick();
        checks++;
        if ({b_valid, b_dout} !== {1'b1, 32'h22}) begin
            errors++;
            $display("FAIL fwft_next got v=%b d=%h want 1 22", b_valid, b_dout);
        end
        tick();
        b_rd = 1'b0;
        checks++;
        if ({b_valid, b_empty, b_under} !== 3'b010) begin
            errors++;
            $display("FAIL fwft_drain got v=%b e=%b u=%b want 0 1 0", b_valid, b_empty, b_under);
        end
    endtask

    task automatic test_enable();
        a_en = 1'b0;
        a_wr = 1'b1;
        a_din = 32'h99;
        tick();
        a_wr = 1'b0;
        checks++;
        if ({a_level, a_empty} !== {5'd0, 1'b1}) begin
            errors++;
            $display("FAIL en_off_wr got lvl=%0d e=%b want 0 1", a_level, a_empty);
        end
        a_rd = 1'b1;
        tick();
        a_rd = 1'b0;
        a_en = 1'b1;
        checks++;
        if ({a_under, a_valid} !== 2'b00) begin
            errors++;
            $display("FAIL en_off_rd got u=%b v=%b want 0 0", a_under, a_valid);
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 10; i++) begin
            a_wr = 1'b1;
            a_din = 32'h100 + DW'(i);
            tick();
        end
        a_wr = 1'b0;
        a_rd = 1'b1;
        tick();
        checks++;
        if ({a_level, a_valid, a_dout} !== {5'd9, 1'b1, 32'h100}) begin
            errors++;
            $display("FAIL pre_flush got lvl=%0d v=%b d=%h want 9 1 100",
                     a_level, a_valid, a_dout);
        end
        a_flush = 1'b1;
        a_wr = 1'b1;
        a_din = 32'hDEAD;
        tick();
        a_flush = 1'b0;
        a_wr = 1'b0;
        a_rd = 1'b0;
        checks++;
        if ({a_level, a_empty, a_valid, a_dout, a_under, a_over}
            !== {5'd0, 1'b1, 1'b0, 32'h100, 2'b00}) begin
            errors++;
            $display("FAIL flush got lvl=%0d e=%b v=%b d=%h u=%b o=%b want 0 1 0 100 0 0",
                     a_level, a_empty, a_valid, a_dout, a_under, a_over);
        end
`ifdef SYNC_FIFO_FLEX_WATERMARK_EN
        checks++;
        if (a_max !== 5'd0) begin
            errors++;
            $display("FAIL flush_max got %0d want 0", a_max);
        end
`endif
        a_wr = 1'b1;
        a_din = 32'h77;
        tick();
        a_wr = 1'b0;
        a_rd = 1'b1;
        tick();
        a_rd = 1'b0;
        checks++;
        if ({a_valid, a_dout, a_empty} !== {1'b1, 32'h77, 1'b1}) begin
            errors++;
            $display("FAIL post_flush got v=%b d=%h e=%b want 1 77 1", a_valid, a_dout, a_empty);
        end
`ifdef SYNC_FIFO_FLEX_WATERMARK_EN
        checks++;
        if (a_max !== 5'd1) begin
            errors++;
            $display("FAIL post_flush_max got %0d want 1", a_max);
        end
`endif
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 7; i++) begin
            a_wr = 1'b1;
            a_din = 32'h30 + DW'(i);
            tick();
        end
        checks++;
        if (a_level !== 5'd7) begin
            errors++;
            $display("FAIL pre_reset_level got %0d want 7", a_level);
        end
        a_din = 32'h40;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({a_level, a_empty, a_full, a_ae, a_af, a_valid, a_dout}
            !== {5'd0, 4'b1010, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL async_reset got lvl=%0d e=%b f=%b ae=%b af=%b v=%b d=%h want 0 1 0 1 0 0 0",
                     a_level, a_empty, a_full, a_ae, a_af, a_valid, a_dout);
        end
`ifdef SYNC_FIFO_FLEX_WATERMARK_EN
        checks++;
        if (a_max !== 5'd0) begin
            errors++;
            $display("FAIL async_reset_max got %0d want 0", a_max);
        end
`endif
        @(negedge clk);
        rst = 1'b0;
        a_din = 32'hA0;
        tick();
        a_din = 32'hA1;
        tick();
        a_wr = 1'b0;
        a_rd = 1'b1;
        tick();
        a_rd = 1'b0;
        checks++;
        if ({a_valid, a_dout, a_level} !== {1'b1, 32'hA0, 5'd1}) begin
            errors++;
            $display("FAIL restart got v=%b d=%h lvl=%0d want 1 a0 1", a_valid, a_dout, a_level);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_fill_overrun();
        test_full_rw();
        test_underrun();
        test_fwft();
        test_enable();
        test_flush();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
